// File: rtl/disp_pkg.sv
// Shared definitions for the display framebuffer read arbiter:
// requester indices, arbiter state encoding and default bus widths.
package disp_pkg;

    localparam int REQ_LCD    = 0;
    localparam int REQ_VGA    = 1;
    localparam int REQ_SPILCD = 2;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/disp_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping to index 0.
// Ports: req_i (requests), ptr_i (priority pointer),
//        gnt_o (one-hot winner), idx_o (winner index), valid when |req_i.
module disp_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   idx_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        // Pass 1: indices at or above the pointer.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_i[j] && (PTR_W'(j) >= ptr_i)) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = PTR_W'(j);
            end
        end
        // Pass 2: wrap around to the indices below the pointer.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_i[j] && (PTR_W'(j) < ptr_i)) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/disp_fb_arbiter.sv
// Burst arbiter sharing one framebuffer read port between display engines.
// Grants whole bursts round-robin, issues sequential reads, routes data back.
// Ports: clk/rst (async active-high), req/req_addr/req_len (per-requester
//        burst request), gnt/rd_data/rd_valid/done (owner side), busy,
//        mem_en/mem_addr/mem_rdata (single-port RAM, RD_LAT read latency).
module disp_fb_arbiter
    import disp_pkg::*;
#(
    parameter int NUM_REQ = REQ_SPILCD + 1,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LEN_W   = 8,
    parameter int RD_LAT  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic                      mem_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    idx_q, idx_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                en_q, en_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                busy_q, busy_d;
    logic [RD_LAT-1:0]   vpipe_q, vpipe_d;
    logic [NUM_REQ-1:0]  rdv_q, rdv_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [PTR_W-1:0]    pick_idx;
    logic [ADDR_W-1:0]   addr_a [NUM_REQ];
    logic [LEN_W-1:0]    len_a  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign len_a[i]  = req_len[i*LEN_W +: LEN_W];
    end

    disp_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            vpipe_q <= '0;
            rdv_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            vpipe_q <= vpipe_d;
            rdv_q   <= rdv_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        en_d    = en_q;
        done_d  = '0;
        // Valid pipe: top bit marks mem_rdata valid this cycle.
        vpipe_d    = '0;
        vpipe_d[0] = en_q;
        for (int k = 1; k < RD_LAT; k++) begin
            vpipe_d[k] = vpipe_q[k-1];
        end
        rdv_d   = vpipe_q[RD_LAT-1] ? gnt_q : '0;
        rdata_d = vpipe_q[RD_LAT-1] ? mem_rdata : rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    en_d    = 1'b1;
                    addr_d  = addr_a[pick_idx];
                    cnt_d   = len_a[pick_idx];
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                // cnt_q counts remaining reads after the current one.
                if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d  = cnt_q - LEN_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                // Pipe empty means the last beat is on rd_valid now.
                if (vpipe_q == '0) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                    if (idx_q == PTR_W'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = idx_q + PTR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign gnt      = gnt_q;
    assign rd_data  = rdata_q;
    assign rd_valid = rdv_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign mem_en   = en_q;
    assign mem_addr = addr_q;

endmodule

// File: tb/tb_disp_fb_arbiter.sv
// Scoreboard bench for disp_fb_arbiter: a transaction-level model predicts
// grants, read addresses, returned beats and done pulses per burst.
module tb_disp_fb_arbiter;

    localparam int NR = 3;
    localparam int AW = 15;
    localparam int DW = 24;
    localparam int LW = 8;
    localparam int RL = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*LW-1:0]  req_len;
    logic [NR-1:0]     gnt;
    logic [DW-1:0]     rd_data;
    logic [NR-1:0]     rd_valid;
    logic [NR-1:0]     done;
    logic              busy;
    logic              mem_en;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_rdata;

    disp_fb_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .LEN_W   (LW),
        .RD_LAT  (RL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .gnt       (gnt),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Framebuffer RAM with RL-cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] mp [RL];
    always @(posedge clk) begin
        mp[0] <= mem_en ? mem[mem_addr] : '0;
        for (int k = 1; k < RL; k++) mp[k] <= mp[k-1];
    end
    assign mem_rdata = mp[RL-1];

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } ev_t;

    ev_t gq[$];
    ev_t aq[$];
    ev_t bq[$];
    ev_t dq[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    logic [NR-1:0] prev_gnt = '0;
    ev_t me;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d",
                      nm, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (gnt != 0 && prev_gnt == 0) begin
                if (gq.size() == 0) chk("gnt_unexp", 64'(gnt), 0);
                else begin
                    me = gq.pop_front();
                    chk("gnt", {cyc, 29'b0, gnt}, {me.cyc, me.val});
                end
            end
            if (mem_en) begin
                if (aq.size() == 0) chk("addr_unexp", 64'(mem_en), 0);
                else begin
                    me = aq.pop_front();
                    chk("addr", {cyc, 17'b0, mem_addr}, {me.cyc, me.val});
                end
            end
            if (rd_valid != 0) begin
                if (bq.size() == 0) chk("beat_unexp", 64'(rd_valid), 0);
                else begin
                    me = bq.pop_front();
                    chk("beat", {cyc, 5'b0, rd_valid, rd_data},
                        {me.cyc, me.val});
                    chk("busy_beat", 64'(busy), 1);
                end
            end
            if (done != 0) begin
                if (dq.size() == 0) chk("done_unexp", 64'(done), 0);
                else begin
                    me = dq.pop_front();
                    chk("done", {cyc, 29'b0, done}, {me.cyc, me.val});
                    chk("done_idle", {gnt, busy}, 0);
                end
            end
        end
        prev_gnt = gnt;
    end

    // Reference model: requester intent plus arbiter timing formulas.
    bit          want [NR];
    bit          keep [NR];
    logic [AW-1:0] raddr [NR];
    logic [LW-1:0] rlen  [NR];
    int          gnt_at [NR];
    int          ptr_m;
    int          free_at;

    task automatic raise(input int i, input logic [AW-1:0] a,
                         input logic [LW-1:0] l, input bit k);
        want[i]  = 1'b1;
        raddr[i] = a;
        rlen[i]  = l;
        keep[i]  = k;
    endtask

    task automatic predict(input int w, input int g);
        int n;
        int idx;
        n = int'(rlen[w]) + 1;
        gq.push_back(ev_t'{g, 32'(1 << w)});
        for (int k = 0; k < n; k++) begin
            idx = (int'(raddr[w]) + k) % (1 << AW);
            aq.push_back(ev_t'{g + k, 32'(idx)});
            bq.push_back(ev_t'{g + RL + 1 + k,
                               {5'b0, 3'(1 << w), mem[idx]}});
        end
        dq.push_back(ev_t'{g + n + RL + 1, 32'(1 << w)});
        free_at   = g + n + RL + 1;
        ptr_m     = (w + 1) % NR;
        gnt_at[w] = g;
    endtask

    task automatic drive_arb();
        int w;
        int j;
        for (int i = 0; i < NR; i++) begin
            req[i]             = want[i];
            req_addr[i*AW +: AW] = raddr[i];
            req_len[i*LW +: LW]  = rlen[i];
        end
        if (cyc >= free_at && (want[0] || want[1] || want[2])) begin
            w = -1;
            for (int k = 0; k < NR; k++) begin
                j = (ptr_m + k) % NR;
                if (w < 0 && want[j]) w = j;
            end
            predict(w, cyc + 1);
        end
    endtask

    // Requester reaction once its grant is visible: params become junk.
    task automatic update();
        for (int i = 0; i < NR; i++) begin
            if (gnt_at[i] == cyc) begin
                gnt_at[i] = -1;
                raddr[i]  = AW'($urandom);
                if (keep[i]) rlen[i] = LW'($urandom_range(0, 5));
                else begin
                    rlen[i] = LW'($urandom);
                    want[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic one();
        drive_arb();
        @(posedge clk);
        #1;
        cyc++;
        update();
    endtask

    task automatic wait_idle(input int budget);
        int b;
        b = 0;
        while ((want[0] || want[1] || want[2] || cyc <= free_at)
               && b < budget) begin
            one();
            b++;
        end
        if (b >= budget) begin
            n_chk++;
            $display("FAIL idle_timeout: still busy after %0d cycles", b);
        end
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_addr = '0;
        req_len  = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        for (int i = 0; i < NR; i++) begin
            want[i]   = 1'b0;
            keep[i]   = 1'b0;
            raddr[i]  = '0;
            rlen[i]   = '0;
            gnt_at[i] = -1;
        end
        ptr_m = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {gnt, rd_valid, done, mem_en, busy, mem_addr,
                         rd_data}, 0);
        rst     = 1'b0;
        cyc     = 0;
        free_at = 0;
        mon_en  = 1'b1;

        // Single burst, then address wrap.
        raise(0, 15'h0010, 8'd3, 1'b0);
        wait_idle(100);
        raise(2, 15'h7FFE, 8'd3, 1'b0);
        wait_idle(100);

        // All three held continuously: strict rotation.
        raise(0, 15'h0100, 8'd2, 1'b1);
        raise(1, 15'h0200, 8'd1, 1'b1);
        raise(2, 15'h0300, 8'd0, 1'b1);
        repeat (60) one();
        for (int i = 0; i < NR; i++) keep[i] = 1'b0;
        wait_idle(200);

        // Max length on req0 with a late req1.
        raise(0, 15'h1234, 8'hFF, 1'b0);
        repeat (5) one();
        raise(1, 15'h4000, 8'd2, 1'b0);
        wait_idle(600);

        // Random traffic, including withdrawals before grant.
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!want[i] && gnt_at[i] < 0
                    && $urandom_range(0, 19) == 0) begin
                    raise(i,
                          ($urandom_range(0, 7) == 0)
                            ? AW'(15'h7FF8 + $urandom_range(0, 7))
                            : AW'($urandom),
                          ($urandom_range(0, 9) == 0)
                            ? LW'($urandom_range(0, 255))
                            : LW'($urandom_range(0, 7)),
                          1'b0);
                end else if (want[i] && gnt_at[i] < 0
                             && $urandom_range(0, 63) == 0) begin
                    want[i] = 1'b0;
                end
            end
            one();
        end
        wait_idle(2000);

        // Reset in the third cycle of a 4-beat burst by req2 (ptr is 2).
        raise(1, 15'h0400, 8'd3, 1'b0);
        wait_idle(100);
        raise(2, 15'h0500, 8'd3, 1'b0);
        one();
        one();
        one();
        rst = 1'b1;
        #1;
        chk("rst_mid", {gnt, rd_valid, done, mem_en, busy, mem_addr,
                        rd_data}, 0);
        gq.delete();
        aq.delete();
        bq.delete();
        dq.delete();
        for (int i = 0; i < NR; i++) begin
            want[i]   = 1'b0;
            gnt_at[i] = -1;
        end
        ptr_m = 0;
        @(posedge clk);
        #1;
        cyc++;
        rst     = 1'b0;
        free_at = cyc;
        for (int k = 0; k < 8; k++) begin
            chk("post_rst_quiet", {gnt, rd_valid, done, mem_en, busy}, 0);
            one();
        end
        // Pointer back at 0: req1 must beat req2.
        raise(1, 15'h0600, 8'd2, 1'b0);
        raise(2, 15'h0700, 8'd2, 1'b0);
        wait_idle(200);
        repeat (4) one();

        chk("left_gnt", 64'(gq.size()), 0);
        chk("left_addr", 64'(aq.size()), 0);
        chk("left_beat", 64'(bq.size()), 0);
        chk("left_done", 64'(dq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
